// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared SRAM word/address types and line reader states
package gpu_mem_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } line_reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count and flush
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop    = pop && (r_count != '0);
    assign valid    = (r_count != '0);
    assign count    = r_count;
    // Gate the head word so the output reads zero while empty, including after reset.
    assign pop_data = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/sram_line_reader.sv
// rtl/sram_line_reader.sv - burst reader from the SRAM controller into a valid/ready stream
module sram_line_reader
    import gpu_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int COUNT_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  sram_addr_t             base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output sram_addr_t             mm_address,
    output logic                   mm_read,
    input  sram_word_t             mm_readdata,
    output logic                   mm_write,
    output sram_word_t             mm_writedata,
    output sram_word_t             out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    line_reader_state_t     r_state;
    sram_addr_t             r_addr;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [LAT_W-1:0]       r_lat;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_mm_read;

    logic [CNT_W-1:0]       w_fifo_count;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_space_next;

    assign w_push       = (r_state == WAIT) && (r_lat == '0) && !abort;
    assign w_pop        = out_valid && out_ready;
    // mm_read is registered, so the space check uses the occupancy the FIFO will hold next cycle.
    assign w_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space_next = (w_count_next < CNT_W'(FIFO_DEPTH));

    assign busy         = r_busy;
    assign done         = r_done;
    assign mm_read      = r_mm_read;
    assign mm_address   = r_addr;
    assign mm_write     = 1'b0;
    assign mm_writedata = '0;

    sync_fifo #(
        .WIDTH(SRAM_DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push     (w_push),
        .push_data(mm_readdata),
        .pop      (w_pop),
        .pop_data (out_data),
        .valid    (out_valid),
        .count    (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mm_read   <= 1'b0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mm_read <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            r_state     <= ISSUE;
                            r_addr      <= base_addr;
                            r_remaining <= word_count;
                            r_busy      <= 1'b1;
                            r_mm_read   <= w_space_next;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (r_mm_read) begin
                        r_state   <= WAIT;
                        r_mm_read <= 1'b0;
                        r_lat     <= LAT_W'(READ_LATENCY - 1);
                    end else begin
                        r_mm_read <= w_space_next;
                    end
                end
                WAIT: begin
                    if (r_lat == '0) begin
                        r_addr      <= r_addr + SRAM_ADDR_W'(1);
                        r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        if (r_remaining == COUNT_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ISSUE;
                            r_mm_read <= w_space_next;
                        end
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_line_reader.sv
// tb/tb_sram_line_reader.sv - scoreboard bench for sram_line_reader
module tb_sram_line_reader;
    import gpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [10:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [19:0] mm_address;
    logic        mm_read;
    logic [15:0] mm_readdata = '0;
    logic        mm_write;
    logic [15:0] mm_writedata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    sram_line_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .mm_address  (mm_address),
        .mm_read     (mm_read),
        .mm_readdata (mm_readdata),
        .mm_write    (mm_write),
        .mm_writedata(mm_writedata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        if (a == 20'h01234) return 16'hAAAA;
        if (a == 20'h01235) return 16'h5555;
        return a[15:0] ^ {a[19:16], 12'h5C3};
    endfunction

    // SRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (mm_read) mm_readdata <= mem_word(mm_address);
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [15:0] exp_data[$];
    logic [19:0] exp_addr[$];
    int read_cyc[$];
    int done_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra_word: got %0h expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    check("stream_data", {16'h0, out_data}, {16'h0, exp_data.pop_front()});
                end
            end
            if (mm_read) begin
                read_cyc.push_back(cyc);
                check("mm_write", {31'h0, mm_write}, 32'h0);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mm_extra_read: got read at %0h expected none (cycle %0d)", mm_address, cyc);
                end else begin
                    check("mm_address", {12'h0, mm_address}, {12'h0, exp_addr.pop_front()});
                end
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [19:0] base, input int cnt);
        logic [19:0] a;
        a = base;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
            a = a + 20'h1;
        end
    endtask

    task automatic start_burst(input logic [19:0] base, input logic [10:0] cnt, output int c0);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        c0         = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((busy || exp_data.size() != 0) && k < bound) begin
            step(1);
            k++;
        end
        check("wait_idle_in_bound", {31'h0, (k < bound)}, 32'h1);
        step(2);
    endtask

    task automatic clear_logs();
        read_cyc.delete();
        done_cyc.delete();
    endtask

    int c0;
    int k;

    initial begin
        step(3);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_mm_read", {31'h0, mm_read}, 0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_mm_address", {12'h0, mm_address}, 0);
        check("rst_out_data", {16'h0, out_data}, 0);
        reset = 1'b0;
        step(3);
        check("post_rst_reads", read_cyc.size(), 0);
        check("post_rst_busy", {31'h0, busy}, 0);

        // reset asserted mid-burst while mm_read is high
        expect_burst(20'h00500, 5);
        start_burst(20'h00500, 11'd5, c0);
        check("midrst_mm_read_pre", {31'h0, mm_read}, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_mm_read", {31'h0, mm_read}, 0);
        check("midrst_busy", {31'h0, busy}, 0);
        check("midrst_mm_address", {12'h0, mm_address}, 0);
        check("midrst_out_valid", {31'h0, out_valid}, 0);
        exp_data.delete();
        exp_addr.delete();
        clear_logs();
        step(1);
        reset = 1'b0;
        step(6);
        check("midrst_no_reads", read_cyc.size(), 0);
        check("midrst_idle", {31'h0, busy}, 0);

        // basic two-word burst
        clear_logs();
        expect_burst(20'h01234, 2);
        start_burst(20'h01234, 11'd2, c0);
        check("basic_busy", {31'h0, busy}, 1);
        wait_idle(50);
        check("basic_reads", read_cyc.size(), 2);
        check("basic_read0_cycle", (read_cyc.size() > 0) ? read_cyc[0] - c0 : -1, 1);
        check("basic_read1_cycle", (read_cyc.size() > 1) ? read_cyc[1] - c0 : -1, 3);
        check("basic_dones", done_cyc.size(), 1);
        check("basic_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, 5);

        // backpressure: FIFO fills to 16 then issue stalls
        clear_logs();
        out_ready = 1'b0;
        expect_burst(20'h00100, 20);
        start_burst(20'h00100, 11'd20, c0);
        step(60);
        check("bp_reads_full", read_cyc.size(), 16);
        check("bp_out_valid", {31'h0, out_valid}, 1);
        step(10);
        check("bp_reads_stall", read_cyc.size(), 16);
        check("bp_mm_read_low", {31'h0, mm_read}, 0);
        out_ready = 1'b1;
        wait_idle(200);
        check("bp_reads_total", read_cyc.size(), 20);
        check("bp_dones", done_cyc.size(), 1);

        // address wrap
        clear_logs();
        expect_burst(20'hFFFFF, 2);
        start_burst(20'hFFFFF, 11'd2, c0);
        wait_idle(50);
        check("wrap_reads", read_cyc.size(), 2);
        check("wrap_dones", done_cyc.size(), 1);

        // zero count
        clear_logs();
        start_burst(20'h00400, 11'd0, c0);
        step(4);
        check("zero_reads", read_cyc.size(), 0);
        check("zero_dones", done_cyc.size(), 1);
        check("zero_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, 1);

        // abort during WAIT of word 3 of 10, with start in the same cycle
        clear_logs();
        out_ready = 1'b0;
        expect_burst(20'h02000, 10);
        start_burst(20'h02000, 11'd10, c0);
        k = 0;
        while (read_cyc.size() < 3 && k < 40) begin
            step(1);
            k++;
        end
        check("abort_reached_word3", read_cyc.size(), 3);
        check("abort_pre_valid", {31'h0, out_valid}, 1);
        check("abort_pre_busy", {31'h0, busy}, 1);
        abort      = 1'b1;
        start      = 1'b1;
        base_addr  = 20'h07000;
        word_count = 11'd4;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        check("abort_busy", {31'h0, busy}, 0);
        check("abort_out_valid", {31'h0, out_valid}, 0);
        out_ready = 1'b1;
        step(10);
        check("abort_no_done", done_cyc.size(), 0);
        check("abort_reads", read_cyc.size(), 3);
        check("abort_start_ignored", {31'h0, busy}, 0);

        // normal burst after abort, with a start pulse while busy
        clear_logs();
        expect_burst(20'h03000, 3);
        start_burst(20'h03000, 11'd3, c0);
        step(1);
        base_addr  = 20'h09000;
        word_count = 11'd7;
        start      = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle(50);
        check("restart_reads", read_cyc.size(), 3);
        check("restart_dones", done_cyc.size(), 1);
        check("restart_addr_left", exp_addr.size(), 0);

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
